// File: rtl/gpr_wb_arbiter.sv
// Round-robin arbiter that shares the single GPR write port among N_REQ writeback sources.
// Defining GPR_WB_BYPASS_EN adds decode-stage bypass ports fed from the registered write.
module gpr_wb_arbiter #(
    parameter int N_REQ = 3,
    parameter int AW    = 5,
    parameter int DW    = 32,
    localparam int IW   = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    output logic                wb_en,
    output logic [AW-1:0]       wb_addr,
    output logic [DW-1:0]       wb_data,
    output logic [IW-1:0]       grant_idx
`ifdef GPR_WB_BYPASS_EN
    ,
    input  logic [AW-1:0]       rd_a1,
    input  logic [AW-1:0]       rd_a2,
    output logic                byp1_hit,
    output logic                byp2_hit,
    output logic [DW-1:0]       byp1_data,
    output logic [DW-1:0]       byp2_data
`endif
);

    logic [IW-1:0]    ptr_r;
    logic [IW-1:0]    cand_s;
    logic [IW-1:0]    gnt_idx_s;
    logic             gnt_vld_s;
    logic [AW-1:0]    gnt_addr_s;
    logic [DW-1:0]    gnt_data_s;
    logic [AW-1:0]    addr_a_s [N_REQ];
    logic [DW-1:0]    data_a_s [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign addr_a_s[g] = req_addr[g*AW +: AW];
        assign data_a_s[g] = req_data[g*DW +: DW];
    end

    // Scan requesters starting just after the previous winner; reset and hold suppress grants.
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_idx_s = '0;
        cand_s    = '0;
        if (!hold && !rst) begin
            for (int k = 1; k <= N_REQ; k++) begin
                cand_s = IW'((int'(ptr_r) + k) % N_REQ);
                if (!gnt_vld_s && req_valid[cand_s]) begin
                    gnt_vld_s = 1'b1;
                    gnt_idx_s = cand_s;
                end else begin
                    gnt_vld_s = gnt_vld_s;
                end
            end
        end else begin
            gnt_vld_s = 1'b0;
        end
    end

    // One-hot ready and the winner's payload.
    always_comb begin
        gnt_addr_s = addr_a_s[gnt_idx_s];
        gnt_data_s = data_a_s[gnt_idx_s];
        if (gnt_vld_s) begin
            req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx_s;
        end else begin
            req_ready = {N_REQ{1'b0}};
        end
    end

    // Register the winning write; a $0 destination completes the handshake without writing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en     <= 1'b0;
            wb_addr   <= {AW{1'b0}};
            wb_data   <= {DW{1'b0}};
            grant_idx <= {IW{1'b0}};
            ptr_r     <= IW'(N_REQ - 1);
        end else if (gnt_vld_s) begin
            wb_en     <= (gnt_addr_s != {AW{1'b0}});
            wb_addr   <= gnt_addr_s;
            wb_data   <= gnt_data_s;
            grant_idx <= gnt_idx_s;
            ptr_r     <= gnt_idx_s;
        end else begin
            wb_en     <= 1'b0;
        end
    end

`ifdef GPR_WB_BYPASS_EN
    // Forward the write the register file commits on the coming edge; $0 never forwards.
    always_comb begin
        byp1_hit = wb_en && (wb_addr == rd_a1) && (rd_a1 != {AW{1'b0}});
        byp2_hit = wb_en && (wb_addr == rd_a2) && (rd_a2 != {AW{1'b0}});
        if (byp1_hit) begin
            byp1_data = wb_data;
        end else begin
            byp1_data = {DW{1'b0}};
        end
        if (byp2_hit) begin
            byp2_data = wb_data;
        end else begin
            byp2_data = {DW{1'b0}};
        end
    end
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Scoreboard bench for gpr_wb_arbiter: a round-robin reference model predicts grants and
// registered writes; a monitor process compares the DUT write port against the queue.
module tb_gpr_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct {
        logic          en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    idx;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            hold;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [DW-1:0]   wb_data;
    logic [1:0]      grant_idx;
`ifdef GPR_WB_BYPASS_EN
    logic [AW-1:0]   rd_a1, rd_a2;
    logic            byp1_hit, byp2_hit;
    logic [DW-1:0]   byp1_data, byp2_data;
`endif

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model state: last winner and the currently presented write.
    int            m_ptr;
    exp_t          m_wb;
    int            wait_c[N];

    gpr_wb_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .grant_idx(grant_idx)
`ifdef GPR_WB_BYPASS_EN
        , .rd_a1(rd_a1), .rd_a2(rd_a2), .byp1_hit(byp1_hit), .byp2_hit(byp2_hit),
        .byp1_data(byp1_data), .byp2_data(byp2_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr   = N - 1;
        m_wb.en = 1'b0; m_wb.addr = '0; m_wb.data = '0; m_wb.idx = '0;
        for (int i = 0; i < N; i++) wait_c[i] = 0;
    endtask

    // Drive one cycle of requests, check the combinational grant, queue the expected write.
    task automatic cycle(input logic h, input logic [N-1:0] v,
                         input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
        int g;
        int cand;
        logic [N-1:0] exp_rdy;
        logic [AW-1:0] aa [N];
        logic [DW-1:0] dd [N];
        @(negedge clk);
        rst = 1'b0; hold = h; req_valid = v; req_addr = a; req_data = d;
        {aa[2], aa[1], aa[0]} = a;
        {dd[2], dd[1], dd[0]} = d;
        #2;
        g = -1;
        if (!h) begin
            for (int k = 1; k <= N; k++) begin
                cand = (m_ptr + k) % N;
                if (g < 0 && v[cand]) g = cand;
            end
        end
        exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        for (int i = 0; i < N; i++) begin
            if (v[i] && !h) begin
                if (req_ready[i]) wait_c[i] = 0;
                else begin
                    wait_c[i]++;
                    chk("fairness", 64'(wait_c[i] < N), 64'd1);
                end
            end else if (!v[i]) begin
                wait_c[i] = 0;
            end
        end
        if (g >= 0) begin
            m_wb.en = (aa[g] != '0); m_wb.addr = aa[g]; m_wb.data = dd[g];
            m_wb.idx = 2'(g); m_ptr = g;
        end else begin
            m_wb.en = 1'b0;
        end
        exp_q.push_back(m_wb);
`ifdef GPR_WB_BYPASS_EN
        rd_a1 = ($urandom_range(1) == 1) ? m_wb.addr : AW'($urandom);
        rd_a2 = AW'($urandom_range(3));
`endif
    endtask

    // Monitor: one expected write per clock edge after stimulus.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("wb_en", 64'(wb_en), 64'(mon_e.en));
            chk("wb_addr", 64'(wb_addr), 64'(mon_e.addr));
            chk("wb_data", 64'(wb_data), 64'(mon_e.data));
            chk("grant_idx", 64'(grant_idx), 64'(mon_e.idx));
`ifdef GPR_WB_BYPASS_EN
            chk("byp1_hit", 64'(byp1_hit), 64'(mon_e.en && mon_e.addr == rd_a1 && rd_a1 != '0));
            chk("byp1_data", 64'(byp1_data),
                (mon_e.en && mon_e.addr == rd_a1 && rd_a1 != '0) ? 64'(mon_e.data) : 64'd0);
            chk("byp2_hit", 64'(byp2_hit), 64'(mon_e.en && mon_e.addr == rd_a2 && rd_a2 != '0));
            chk("byp2_data", 64'(byp2_data),
                (mon_e.en && mon_e.addr == rd_a2 && rd_a2 != '0) ? 64'(mon_e.data) : 64'd0);
`endif
        end
    end

    initial begin
        logic [N*AW-1:0] ra;
        logic [N*DW-1:0] rd;
        rst = 1'b1; hold = 1'b0; req_valid = 3'b111;
        req_addr = {5'd7, 5'd6, 5'd5};
        req_data = {32'hC, 32'hB, 32'hA};
`ifdef GPR_WB_BYPASS_EN
        rd_a1 = '0; rd_a2 = '0;
`endif
        model_reset();
        @(negedge clk); #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_wb_en", 64'(wb_en), 64'd0);
        chk("rst_wb_addr", 64'(wb_addr), 64'd0);
        chk("rst_wb_data", 64'(wb_data), 64'd0);
        chk("rst_grant_idx", 64'(grant_idx), 64'd0);

        // Rotation with all three valid, starting right after reset release.
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 3'b111, {5'd7, 5'd6, 5'd5}, {32'hC, 32'hB, 32'hA});

        // Freeze, then requester 1 wins first.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 3'b110, {5'd7, 5'd6, 5'd5}, {32'hC, 32'hB, 32'hA});
        cycle(1'b0, 3'b110, {5'd7, 5'd6, 5'd5}, {32'hC, 32'hB, 32'hA});

        // Write to $0 completes the handshake but does not enable the write.
        cycle(1'b0, 3'b010, {5'd7, 5'd0, 5'd5}, {32'hC, 32'hFFFFFFFF, 32'hA});
        cycle(1'b0, 3'b000, {5'd7, 5'd0, 5'd5}, {32'hC, 32'hFFFFFFFF, 32'hA});

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                ra[i*AW +: AW] = ($urandom_range(7) == 0) ? 5'd0 : AW'($urandom);
                rd[i*DW +: DW] = $urandom;
            end
            cycle($urandom_range(7) == 0, N'($urandom), ra, rd);
        end

`ifdef GPR_WB_BYPASS_EN
        cycle(1'b0, 3'b001, {5'd0, 5'd0, 5'd3}, {32'h0, 32'h0, 32'h1234});
        rd_a1 = 5'd3; rd_a2 = 5'd0;
        #5;
        chk("byp_dir_hit1", 64'(byp1_hit), 64'd1);
        chk("byp_dir_data1", 64'(byp1_data), 64'h1234);
        chk("byp_dir_hit2", 64'(byp2_hit), 64'd0);
        chk("byp_dir_data2", 64'(byp2_data), 64'd0);
`endif

        // Asynchronous reset while a write to $9 is on the port.
        cycle(1'b0, 3'b001, {5'd0, 5'd0, 5'd9}, {32'h0, 32'h0, 32'h99});
        #5;
        chk("pre_rst_wb_en", 64'(wb_en), 64'd1);
        chk("pre_rst_wb_addr", 64'(wb_addr), 64'd9);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_wb_en", 64'(wb_en), 64'd0);
        chk("async_rst_wb_addr", 64'(wb_addr), 64'd0);
        chk("async_rst_ready", 64'(req_ready), 64'd0);
        model_reset();
        exp_q.delete();
        @(posedge clk); #1;
        chk("in_rst_wb_en", 64'(wb_en), 64'd0);
        cycle(1'b0, 3'b111, {5'd7, 5'd6, 5'd5}, {32'hC, 32'hB, 32'hA});
        cycle(1'b0, 3'b000, {5'd7, 5'd6, 5'd5}, {32'hC, 32'hB, 32'hA});
        @(posedge clk); #3;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
